// File: rtl/alu_ctrl_md.sv
// alu_ctrl_md: ALU control decode plus iterative unsigned mult/div sequencer with HI/LO
module alu_ctrl_md #(
  parameter int DATA_W  = 32,
  parameter int ALUOP_W = 3
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               valid_i,
  input  logic [5:0]         funct_i,
  input  logic [ALUOP_W-1:0] ALUOp_i,
  input  logic [DATA_W-1:0]  rs_data_i,
  input  logic [DATA_W-1:0]  rt_data_i,
  output logic [3:0]         ALUCtrl_o,
  output logic               Jr_o,
  output logic               stall_o,
  output logic               md_done_o,
  output logic [DATA_W-1:0]  mf_data_o,
  output logic [DATA_W-1:0]  hi_o,
  output logic [DATA_W-1:0]  lo_o
);
  localparam int CW = $clog2(DATA_W);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t                  state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic                    div_q, div_d;
  logic [DATA_W-1:0]       m_q, m_d, hi_q, hi_d, lo_q, lo_d, dif;
  logic [2*DATA_W-1:0]     p_q, p_d, p_nx;
  logic [DATA_W:0]         sum;
  logic                    r_op, ge, start;
  assign r_op  = ALUOp_i == '0;
  assign start = valid_i & r_op & (funct_i == 6'h19 | funct_i == 6'h1B);
  assign hi_o  = hi_q;
  assign lo_o  = lo_q;
  // ALU control, jr select and HI/LO read-out decode
  always_comb begin
    Jr_o      = r_op & (funct_i == 6'd8);
    ALUCtrl_o = (ALUOp_i == ALUOP_W'(4)) ? 4'd6 :
                (ALUOp_i == ALUOP_W'(2)) ? 4'd7 :
                (ALUOp_i == ALUOP_W'(1)) ? 4'd2 :
                !r_op                    ? 4'd15 :
                (funct_i == 6'd32)       ? 4'd2 :
                (funct_i == 6'd34)       ? 4'd6 :
                (funct_i == 6'd36)       ? 4'd0 :
                (funct_i == 6'd37)       ? 4'd1 :
                (funct_i == 6'd42)       ? 4'd7 : 4'd15;
    mf_data_o = (r_op & funct_i == 6'h10) ? hi_q :
                (r_op & funct_i == 6'h12) ? lo_q : '0;
  end
  // One shift-add or restoring-divide step on the {upper, lower} working register
  always_comb begin
    sum  = {1'b0, p_q[2*DATA_W-1:DATA_W]} + (p_q[0] ? {1'b0, m_q} : '0);
    ge   = p_q[2*DATA_W-1:DATA_W-1] >= {1'b0, m_q};
    dif  = p_q[2*DATA_W-2:DATA_W-1] - m_q;
    p_nx = !div_q ? {sum, p_q[DATA_W-1:1]} :
           ge     ? {dif, p_q[DATA_W-2:0], 1'b1} : {p_q[2*DATA_W-2:0], 1'b0};
  end
  // Sequencer next state, stall and completion pulse
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    div_d     = div_q;
    m_d       = m_q;
    p_d       = p_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    stall_o   = 1'b0;
    md_done_o = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        stall_o = 1'b1;
        state_d = BUSY;
        cnt_d   = '0;
        div_d   = funct_i == 6'h1B;
        m_d     = (funct_i == 6'h1B) ? rt_data_i : rs_data_i;
        p_d     = {{DATA_W{1'b0}}, (funct_i == 6'h1B) ? rs_data_i : rt_data_i};
      end
      BUSY: begin
        stall_o = 1'b1;
        p_d     = p_nx;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == CW'(DATA_W-1)) begin
          hi_d    = p_nx[2*DATA_W-1:DATA_W];
          lo_d    = p_nx[DATA_W-1:0];
          state_d = DONE;
        end
      end
      DONE: begin
        md_done_o = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (rst_i) begin
      stall_o   = 1'b0;
      md_done_o = 1'b0;
    end
  end
  // State, operand and HI/LO registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      div_q   <= 1'b0;
      m_q     <= '0;
      p_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      m_q     <= m_d;
      p_q     <= p_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end
endmodule
